// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, addresses the instruction memory, loads IF/ID.
// Latency: PC and IF/ID update one edge after a decision; im_addr follows pc combinationally.
// Backpressure: level 'stall' freezes PC, IF/ID and state; exception/eret redirects override it.
//
// Ports: clk/reset (sync, active-low); stall, br_taken/br_target, exc_req, eret/epc steer the next PC;
//        im_addr/im_data form the combinational memory read; pc is the fetch PC; if_* is the IF/ID register.
// Optional build macro FETCH_ADDR_CHECK_EN: flags misaligned or out-of-range fetches as AdEL in IF/ID.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter logic [31:0] PC_LO    = 32'h0000_3000,
   parameter logic [31:0] PC_HI    = 32'h0000_4FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [10:0] im_addr,
   input  logic [31:0] im_data,
   output logic [31:0] pc,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        if_exc,
   output logic [4:0]  if_exccode
);

`ifdef FETCH_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic        valid_q, valid_d;
   logic        exc_q, exc_d;
   logic        fetch_bad;

   // Constant-folds to 0 when the check is not compiled in.
   assign fetch_bad = ADDR_CHECK && ((pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      valid_d = valid_q;
      exc_d   = exc_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN, ST_FLUSH: begin
            // Redirect requests are only honoured in RUN; the FLUSH cycle masks a
            // request that CP0 has not yet dropped.
            if (state_q == ST_RUN && exc_req) begin
               pc_d    = EXC_PC;
               instr_d = 32'h0;
               valid_d = 1'b0;
               exc_d   = 1'b0;
               state_d = ST_FLUSH;
            end else if (state_q == ST_RUN && eret) begin
               pc_d    = epc;
               instr_d = 32'h0;
               valid_d = 1'b0;
               exc_d   = 1'b0;
               state_d = ST_FLUSH;
            end else if (stall) begin
               // hold everything, including state
            end else begin
               pc_d    = br_taken ? br_target : pc_q + 32'd4;
               // A bad fetch still occupies the slot so the fault reaches CP0 in order.
               instr_d = fetch_bad ? 32'h0 : im_data;
               ifpc_d  = pc_q;
               valid_d = 1'b1;
               exc_d   = fetch_bad;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         ifpc_q  <= 32'h0;
         valid_q <= 1'b0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         valid_q <= valid_d;
         exc_q   <= exc_d;
      end
   end

   // The memory strips its own base; only the 11-bit word index is driven.
   assign im_addr    = pc_q[12:2];
   assign pc         = pc_q;
   assign if_instr   = instr_q;
   assign if_pc      = ifpc_q;
   assign if_valid   = valid_q;
   assign if_exc     = exc_q;
   assign if_exccode = exc_q ? EXC_ADEL : 5'd0;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        reset, stall, br_taken, exc_req, eret;
   logic [31:0] br_target, epc, im_data;
   logic [10:0] im_addr;
   logic [31:0] pc, if_instr, if_pc;
   logic        if_valid, if_exc;
   logic [4:0]  if_exccode;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
      .exc_req(exc_req), .eret(eret), .epc(epc), .im_addr(im_addr), .im_data(im_data),
      .pc(pc), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .if_exc(if_exc), .if_exccode(if_exccode)
   );

   // Instruction memory stand-in: each word is tagged with its own word index.
   function automatic logic [31:0] mem_word(input logic [10:0] a);
      return 32'hA500_0000 | {21'h0, a};
   endfunction

   always_comb im_data = mem_word(im_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      exc_req = 1'b0; eret = 1'b0; epc = 32'h0;
      step(); step();
      checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
      checks++; if (im_addr !== 11'h400) begin failures++; $display("FAIL reset_im_addr got=%h exp=%h", im_addr, 11'h400); end
      checks++; if ({if_valid, if_exc, if_exccode} !== 7'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {if_valid, if_exc, if_exccode}); end
      checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin failures++; $display("FAIL reset_ifid got=%h/%h exp=0/0", if_instr, if_pc); end
   endtask

   task automatic test_boot();
      reset = 1'b1;
      step();  // BOOT cycle
      checks++; if (pc !== 32'h3000 || if_valid !== 1'b0) begin failures++; $display("FAIL boot_hold got pc=%h v=%b exp pc=3000 v=0", pc, if_valid); end
      step();
      checks++; if (if_pc !== 32'h3000 || if_valid !== 1'b1 || if_instr !== mem_word(11'h400)) begin failures++; $display("FAIL first_fetch got pc=%h v=%b i=%h exp 3000/1/%h", if_pc, if_valid, if_instr, mem_word(11'h400)); end
      checks++; if (pc !== 32'h3004) begin failures++; $display("FAIL first_pc got=%h exp=3004", pc); end
      step();
      checks++; if (if_pc !== 32'h3004 || if_instr !== mem_word(11'h401)) begin failures++; $display("FAIL seq_3004 got=%h/%h exp=3004/%h", if_pc, if_instr, mem_word(11'h401)); end
      step();
      checks++; if (if_pc !== 32'h3008 || pc !== 32'h300C) begin failures++; $display("FAIL seq_3008 got if_pc=%h pc=%h exp 3008/300c", if_pc, pc); end
      step();
      checks++; if (pc !== 32'h3010 || im_addr !== 11'h404) begin failures++; $display("FAIL seq_3010 got pc=%h a=%h exp 3010/404", pc, im_addr); end
   endtask

   task automatic test_branch();
      br_taken = 1'b1; br_target = 32'h3040;
      step();
      checks++; if (pc !== 32'h3040) begin failures++; $display("FAIL br_pc got=%h exp=3040", pc); end
      checks++; if (if_pc !== 32'h3010 || if_instr !== mem_word(11'h404) || if_valid !== 1'b1) begin failures++; $display("FAIL br_delay_slot got=%h/%h/%b exp 3010/%h/1", if_pc, if_instr, if_valid, mem_word(11'h404)); end
      br_taken = 1'b0;
      step();
      checks++; if (if_pc !== 32'h3040 || if_instr !== mem_word(11'h410) || pc !== 32'h3044) begin failures++; $display("FAIL br_target_ifid got=%h/%h pc=%h exp 3040/%h pc=3044", if_pc, if_instr, pc, mem_word(11'h410)); end
   endtask

   task automatic test_stall();
      stall = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== 32'h3044 || if_pc !== 32'h3040 || if_instr !== mem_word(11'h410) || if_valid !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] got pc=%h if_pc=%h i=%h v=%b exp 3044/3040", i, pc, if_pc, if_instr, if_valid); end
      end
      stall = 1'b0; br_taken = 1'b0;
      step();
      checks++; if (pc !== 32'h3048 || if_pc !== 32'h3044) begin failures++; $display("FAIL stall_resume got pc=%h if_pc=%h exp 3048/3044", pc, if_pc); end
   endtask

   task automatic test_exception();
      exc_req = 1'b1; stall = 1'b1; eret = 1'b1; epc = 32'h3024;
      step();
      checks++; if (pc !== 32'h4180) begin failures++; $display("FAIL exc_pc got=%h exp=4180", pc); end
      checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_exc !== 1'b0) begin failures++; $display("FAIL exc_flush got v=%b i=%h e=%b exp 0/0/0", if_valid, if_instr, if_exc); end
      stall = 1'b0; eret = 1'b0;  // exc_req still held
      step();
      checks++; if (pc !== 32'h4184) begin failures++; $display("FAIL exc_reentry got=%h exp=4184", pc); end
      checks++; if (if_pc !== 32'h4180 || if_valid !== 1'b1 || if_instr !== mem_word(11'h060)) begin failures++; $display("FAIL exc_handler_ifid got=%h/%b/%h exp 4180/1/%h", if_pc, if_valid, if_instr, mem_word(11'h060)); end
      exc_req = 1'b0;
      step();
      checks++; if (pc !== 32'h4188 || if_pc !== 32'h4184) begin failures++; $display("FAIL exc_seq got pc=%h if_pc=%h exp 4188/4184", pc, if_pc); end
   endtask

   task automatic test_eret_reset();
      eret = 1'b1; epc = 32'h3024;
      step();
      checks++; if (pc !== 32'h3024 || if_valid !== 1'b0) begin failures++; $display("FAIL eret_pc got pc=%h v=%b exp 3024/0", pc, if_valid); end
      eret = 1'b0;
      step();
      checks++; if (if_pc !== 32'h3024 || if_valid !== 1'b1 || pc !== 32'h3028 || if_instr !== mem_word(11'h409)) begin failures++; $display("FAIL eret_ifid got if_pc=%h v=%b pc=%h i=%h exp 3024/1/3028", if_pc, if_valid, pc, if_instr); end
      reset = 1'b0; br_taken = 1'b1; br_target = 32'h3200;
      step();
      checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL midreset_pc got=%h exp=3000", pc); end
      checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_valid !== 1'b0 || if_exc !== 1'b0 || if_exccode !== 5'd0) begin failures++; $display("FAIL midreset_ifid got %h/%h/%b/%b/%h exp all 0", if_instr, if_pc, if_valid, if_exc, if_exccode); end
      reset = 1'b1; br_taken = 1'b0;
      step(); step();
      checks++; if (pc !== 32'h3004 || if_pc !== 32'h3000) begin failures++; $display("FAIL midreset_restart got pc=%h if_pc=%h exp 3004/3000", pc, if_pc); end
   endtask

   task automatic test_addr_check();
      br_taken = 1'b1; br_target = 32'h5000;
      step();
      checks++; if (pc !== 32'h5000 || if_pc !== 32'h3004 || if_exc !== 1'b0) begin failures++; $display("FAIL oob_branch got pc=%h if_pc=%h e=%b exp 5000/3004/0", pc, if_pc, if_exc); end
      br_taken = 1'b0;
      step();
      checks++; if (if_pc !== 32'h5000 || if_valid !== 1'b1 || pc !== 32'h5004) begin failures++; $display("FAIL oob_slot got if_pc=%h v=%b pc=%h exp 5000/1/5004", if_pc, if_valid, pc); end
`ifdef FETCH_ADDR_CHECK_EN
      checks++; if (if_exc !== 1'b1 || if_exccode !== 5'd4 || if_instr !== 32'h0) begin failures++; $display("FAIL oob_adel got e=%b c=%h i=%h exp 1/4/0", if_exc, if_exccode, if_instr); end
`else
      checks++; if (if_exc !== 1'b0 || if_exccode !== 5'd0 || if_instr !== mem_word(11'h400)) begin failures++; $display("FAIL oob_nocheck got e=%b c=%h i=%h exp 0/0/%h", if_exc, if_exccode, if_instr, mem_word(11'h400)); end
`endif
      // Back into range: the fault marker must clear on the next legal fetch.
      br_taken = 1'b1; br_target = 32'h3100;
      step();
      br_taken = 1'b0;
      step();
      checks++; if (if_pc !== 32'h3100 || if_exc !== 1'b0 || if_instr !== mem_word(11'h440)) begin failures++; $display("FAIL legal_after_oob got if_pc=%h e=%b i=%h exp 3100/0/%h", if_pc, if_exc, if_instr, mem_word(11'h440)); end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_branch();
      test_stall();
      test_exception();
      test_eret_reset();
      test_addr_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
